// File: rtl/seg7_reader_if.sv
// Segment bus and monitor outputs of the seven-segment reader.
// The display side drives seg_in; the reader returns decoded digits and error status.
interface seg7_reader_if;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       pattern_err;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    modport master (
        output seg_in,
        input  digit, digit_valid, pattern_err, seq_err, locked, err_count
    );

    modport slave (
        input  seg_in,
        output digit, digit_valid, pattern_err, seq_err, locked, err_count
    );
endinterface

// File: rtl/seg7_reader.sv
// Seven-segment pattern reader: debounces the segment bus, decodes settled patterns
// to hex digits and checks that digits count up by one modulo 16.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg7_reader_if.slave  bus
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Returns {valid, blank, digit}; an all-zero result means an invalid pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h3F: r = 6'b10_0000;
            7'h06: r = 6'b10_0001;
            7'h5B: r = 6'b10_0010;
            7'h4F: r = 6'b10_0011;
            7'h66: r = 6'b10_0100;
            7'h6D: r = 6'b10_0101;
            7'h7D: r = 6'b10_0110;
            7'h07: r = 6'b10_0111;
            7'h7F: r = 6'b10_1000;
            7'h6F: r = 6'b10_1001;
            7'h77: r = 6'b10_1010;
            7'h7C: r = 6'b10_1011;
            7'h39: r = 6'b10_1100;
            7'h5E: r = 6'b10_1101;
            7'h79: r = 6'b10_1110;
            7'h71: r = 6'b10_1111;
            7'h00: r = 6'b01_0000;
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [6:0]       seg_q, seg_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [6:0]       last_pat_q, last_pat_d;
    logic             last_vld_q, last_vld_d;
    logic [0:0]       state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             pattern_err_q, pattern_err_d;
    logic             seq_err_q, seq_err_d;
    logic             locked_q, locked_d;
    logic [7:0]       err_count_q, err_count_d;

    logic       same;
    logic       accept;
    logic [5:0] dec;
    logic       dec_valid;
    logic       dec_blank;
    logic [3:0] dec_digit;

    always_comb begin
        seg_d         = bus.seg_in;
        stab_cnt_d    = stab_cnt_q;
        last_pat_d    = last_pat_q;
        last_vld_d    = last_vld_q;
        state_d       = state_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        pattern_err_d = 1'b0;
        seq_err_d     = 1'b0;
        locked_d      = locked_q;
        err_count_d   = err_count_q;

        same      = (bus.seg_in == seg_q);
        dec       = decode_seg(seg_q);
        dec_valid = dec[5];
        dec_blank = dec[4];
        dec_digit = dec[3:0];

        if (!same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end

        // Re-accepting the previous pattern is suppressed, so a glitch that returns
        // to the displayed value reports nothing.
        accept = same && (stab_cnt_q == CNT_MAX) && (!last_vld_q || (seg_q != last_pat_q));

        if (accept) begin
            last_pat_d = seg_q;
            last_vld_d = 1'b1;
            if (dec_blank) begin
                locked_d = 1'b0;
                state_d  = ST_IDLE;
            end else if (!dec_valid) begin
                pattern_err_d = 1'b1;
                locked_d      = 1'b0;
                state_d       = ST_IDLE;
                err_count_d   = sat_inc8(err_count_q);
            end else begin
                digit_d       = dec_digit;
                digit_valid_d = 1'b1;
                if (state_q == ST_IDLE) begin
                    state_d  = ST_TRACK;
                    locked_d = 1'b0;
                end else if (dec_digit == digit_q + 4'd1) begin
                    locked_d = 1'b1;
                end else begin
                    seq_err_d   = 1'b1;
                    locked_d    = 1'b0;
                    err_count_d = sat_inc8(err_count_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= '0;
            stab_cnt_q    <= '0;
            last_pat_q    <= '0;
            last_vld_q    <= 1'b0;
            state_q       <= ST_IDLE;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
            err_count_q   <= '0;
        end else begin
            seg_q         <= seg_d;
            stab_cnt_q    <= stab_cnt_d;
            last_pat_q    <= last_pat_d;
            last_vld_q    <= last_vld_d;
            state_q       <= state_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            pattern_err_q <= pattern_err_d;
            seq_err_q     <= seq_err_d;
            locked_q      <= locked_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.locked      = locked_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES=4: reset, counting sweep,
// glitch rejection, sequence/pattern errors, saturation and mid-operation reset.
module tb_seg7_reader;

    logic clk;
    logic rst;
    seg7_reader_if bus();

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int dv_cnt, pe_cnt, se_cnt, both_cnt, dv_at;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0; both_cnt = 0; dv_at = 0;
    endtask

    // Drive a pattern for n edges, sampling outputs 1 time unit after each edge.
    task automatic hold(input logic [6:0] p, input int n);
        bus.seg_in = p;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (bus.digit_valid) begin
                dv_cnt++;
                if (dv_at == 0) dv_at = i;
            end
            if (bus.pattern_err) pe_cnt++;
            if (bus.seq_err) se_cnt++;
            if (bus.digit_valid && bus.seq_err) both_cnt++;
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_digit"}, 32'(bus.digit), 32'd0);
        check_eq({tag, "_dv"},    32'(bus.digit_valid), 32'd0);
        check_eq({tag, "_perr"},  32'(bus.pattern_err), 32'd0);
        check_eq({tag, "_serr"},  32'(bus.seq_err), 32'd0);
        check_eq({tag, "_lock"},  32'(bus.locked), 32'd0);
        check_eq({tag, "_errc"},  32'(bus.err_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.seg_in = 7'h3F;
        clr_counts();

        // Reset hold with a valid pattern on the bus
        repeat (2) begin
            @(posedge clk); #1;
            check_cleared("rst");
        end
        rst = 1'b0;
        hold(7'h3F, 6);
        check_eq("rst_dv_edge", 32'(dv_at), 32'd5);
        check_eq("rst_dv_cnt",  32'(dv_cnt), 32'd1);
        check_eq("rst_digit",   32'(bus.digit), 32'd0);
        check_eq("rst_lock",    32'(bus.locked), 32'd0);
        check_eq("rst_dv_drop", 32'(bus.digit_valid), 32'd0);

        // Blank restarts sequencing so the sweep can begin at 0
        clr_counts();
        hold(7'h00, 10);
        check_eq("blank_dv",   32'(dv_cnt), 32'd0);
        check_eq("blank_lock", 32'(bus.locked), 32'd0);

        // Counting sweep 0..F..0
        for (int i = 0; i <= 16; i++) begin
            clr_counts();
            hold(seg_tab[i % 16], 10);
            check_eq($sformatf("sweep%0d_dv", i),    32'(dv_cnt), 32'd1);
            check_eq($sformatf("sweep%0d_digit", i), 32'(bus.digit), 32'(i % 16));
            check_eq($sformatf("sweep%0d_lock", i),  32'(bus.locked), (i != 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("sweep%0d_serr", i),  32'(se_cnt), 32'd0);
        end
        check_eq("sweep_errc", 32'(bus.err_count), 32'd0);

        // Glitch rejection on digit 2
        hold(7'h06, 10);
        hold(7'h5B, 10);
        check_eq("pre_glitch_digit", 32'(bus.digit), 32'd2);
        clr_counts();
        hold(7'h66, 3);
        hold(7'h5B, 12);
        check_eq("glitch_dv",    32'(dv_cnt), 32'd0);
        check_eq("glitch_perr",  32'(pe_cnt), 32'd0);
        check_eq("glitch_serr",  32'(se_cnt), 32'd0);
        check_eq("glitch_digit", 32'(bus.digit), 32'd2);
        check_eq("glitch_lock",  32'(bus.locked), 32'd1);

        // Sequence error 3 -> 5, then 6 relocks
        clr_counts();
        hold(7'h4F, 10);
        check_eq("seq3_digit", 32'(bus.digit), 32'd3);
        check_eq("seq3_lock",  32'(bus.locked), 32'd1);
        clr_counts();
        hold(7'h6D, 10);
        check_eq("seq5_both",  32'(both_cnt), 32'd1);
        check_eq("seq5_serr",  32'(se_cnt), 32'd1);
        check_eq("seq5_digit", 32'(bus.digit), 32'd5);
        check_eq("seq5_lock",  32'(bus.locked), 32'd0);
        check_eq("seq5_errc",  32'(bus.err_count), 32'd1);
        clr_counts();
        hold(7'h7D, 10);
        check_eq("seq6_lock", 32'(bus.locked), 32'd1);
        check_eq("seq6_serr", 32'(se_cnt), 32'd0);

        // Blank between 8 and 0, then invalid pattern
        hold(7'h07, 10);
        hold(7'h7F, 10);
        check_eq("b8_digit", 32'(bus.digit), 32'd8);
        check_eq("b8_lock",  32'(bus.locked), 32'd1);
        clr_counts();
        hold(7'h00, 10);
        check_eq("bl_dv",    32'(dv_cnt), 32'd0);
        check_eq("bl_lock",  32'(bus.locked), 32'd0);
        check_eq("bl_digit", 32'(bus.digit), 32'd8);
        clr_counts();
        hold(7'h3F, 10);
        check_eq("b0_dv",    32'(dv_cnt), 32'd1);
        check_eq("b0_serr",  32'(se_cnt), 32'd0);
        check_eq("b0_digit", 32'(bus.digit), 32'd0);
        check_eq("b0_lock",  32'(bus.locked), 32'd0);
        hold(7'h06, 10);
        check_eq("b1_lock",  32'(bus.locked), 32'd1);
        clr_counts();
        hold(7'h01, 10);
        check_eq("inv_perr",  32'(pe_cnt), 32'd1);
        check_eq("inv_dv",    32'(dv_cnt), 32'd0);
        check_eq("inv_digit", 32'(bus.digit), 32'd1);
        check_eq("inv_lock",  32'(bus.locked), 32'd0);
        check_eq("inv_errc",  32'(bus.err_count), 32'd2);

        // Saturation: 300 further invalid accepts
        clr_counts();
        for (int k = 1; k <= 300; k++) begin
            hold((k % 2 == 1) ? 7'h02 : 7'h01, 5);
            if (k == 252) check_eq("sat_254", 32'(bus.err_count), 32'd254);
            if (k == 253) check_eq("sat_255", 32'(bus.err_count), 32'd255);
        end
        check_eq("sat_final", 32'(bus.err_count), 32'd255);
        check_eq("sat_perr",  32'(pe_cnt), 32'd300);
        hold(7'h7D, 10);
        check_eq("post_sat_digit", 32'(bus.digit), 32'd6);
        check_eq("post_sat_lock",  32'(bus.locked), 32'd0);

        // Reset while a new pattern is settling (stab_cnt == 2)
        clr_counts();
        hold(7'h06, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_cleared("mid_rst");
        rst = 1'b0;
        clr_counts();
        hold(7'h06, 6);
        check_eq("mid_dv_edge", 32'(dv_at), 32'd5);
        check_eq("mid_dv_cnt",  32'(dv_cnt), 32'd1);
        check_eq("mid_digit",   32'(bus.digit), 32'd1);
        check_eq("mid_lock",    32'(bus.locked), 32'd0);
        check_eq("mid_errc",    32'(bus.err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
